lfsr_gen: RTL

Parametrised next-generation LFSR for the TT tile designs: configurable width, tap mask and steps per clock. Fibonacci/Galois mode is selectable at run time. The block adds a seed guard, a step counter and hardware period measurement (wrap detection). It sits behind the tile wrapper, with the seed on `ui_in`, the state on `uo_out` and control on `uio_in`.

---
 rtl/lfsr_pkg.sv | 27 ++
 rtl/lfsr_step.sv | 29 ++
 rtl/lfsr_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the configurable LFSR generator.
package lfsr_pkg;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    // Reverse the lowest w bits of v; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

    // Even/odd parity of a vector: 1 when an odd number of bits are set.
    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step in either Fibonacci or Galois form.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16)
) (
    input  logic [WIDTH-1:0] s_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] s_o,
    output logic             out_o
);

    // The Galois mask maps x^(i+1) to bit i; the Fibonacci feedback reads the mirror image.
    localparam logic [WIDTH-1:0] FIB_MASK = WIDTH'(bitrev(32'(TAPS), WIDTH));

    logic feedback;

    // Shift right by one, either folding the tap mask in (Galois) or feeding parity into the MSB (Fibonacci).
    always_comb begin
        out_o    = s_i[0];
        feedback = parity(32'(s_i & FIB_MASK));
        s_o      = {feedback, s_i[WIDTH-1:1]};
        if (mode_i == MODE_GAL) begin
            s_o = (s_i >> 1) ^ (s_i[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Multi-step LFSR with seed guard, step counter and period measurement.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(TAPS_16),
    parameter int               STEPS      = 1,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
    parameter int               CNT_W      = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             en_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] state_o,
    output logic [STEPS-1:0] out_bits_o,
    output logic [CNT_W-1:0] step_cnt_o,
    output logic             wrap_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [STEPS-1:0] out_bits_q, out_bits_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;

    logic [STEPS-1:0] stepOut;
    logic [WIDTH-1:0] finalState;
    logic [WIDTH-1:0] effSeed;
    logic [CNT_W-1:0] cntNext;

    // Chain STEPS single-step stages; each stage feeds the next and contributes one output bit.
    for (genvar g = 0; g < STEPS; g++) begin : gStep
        logic [WIDTH-1:0] sIn;
        logic [WIDTH-1:0] sOut;
        if (g == 0) begin : gFirst
            assign sIn = state_q;
        end else begin : gNext
            assign sIn = gStep[g-1].sOut;
        end
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) uStep (
            .s_i    (sIn),
            .mode_i (mode_i),
            .s_o    (sOut),
            .out_o  (stepOut[g])
        );
    end

    assign finalState = gStep[STEPS-1].sOut;

    // Load beats enable; an enabled cycle advances the state and counter, flagging a wrap when the seed comes back.
    always_comb begin
        state_d        = state_q;
        seed_d         = seed_q;
        out_bits_d     = out_bits_q;
        step_cnt_d     = step_cnt_q;
        wrap_d         = 1'b0;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        effSeed        = (seed_i == '0) ? RESET_SEED : seed_i;
        cntNext        = step_cnt_q + CNT_W'(STEPS);
        if (load_i) begin
            state_d    = effSeed;
            seed_d     = effSeed;
            step_cnt_d = '0;
        end else if (en_i) begin
            state_d    = finalState;
            out_bits_d = stepOut;
            if (finalState == seed_q) begin
                wrap_d         = 1'b1;
                period_d       = cntNext;
                period_valid_d = 1'b1;
                step_cnt_d     = '0;
            end else begin
                step_cnt_d = cntNext;
            end
        end
    end

    // Register every output; reset is synchronous and wins over load and enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RESET_SEED;
            seed_q         <= RESET_SEED;
            out_bits_q     <= '0;
            step_cnt_q     <= '0;
            wrap_q         <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seed_q         <= seed_d;
            out_bits_q     <= out_bits_d;
            step_cnt_q     <= step_cnt_d;
            wrap_q         <= wrap_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign state_o        = state_q;
    assign out_bits_o     = out_bits_q;
    assign step_cnt_o     = step_cnt_q;
    assign wrap_o         = wrap_q;
    assign period_o       = period_q;
    assign period_valid_o = period_valid_q;

endmodule
